// File: rtl/program_loader_pkg.sv
// Shared definitions for the program loader and the washing-machine sequencer.
// Holds loader state encoding, instruction field layout and opcode values.
// Pure declarations; no logic.
package program_loader_pkg;

   // Loader state encoding, kept as fixed constants so older tools and
   // existing debug scripts see stable state codes.
   localparam logic [2:0] ST_IDLE = 3'd0;
   localparam logic [2:0] ST_LEN  = 3'd1;
   localparam logic [2:0] ST_LO   = 3'd2;
   localparam logic [2:0] ST_HI   = 3'd3;
   localparam logic [2:0] ST_SUM  = 3'd4;
   localparam logic [2:0] ST_RUN  = 3'd5;
   localparam logic [2:0] ST_ERR  = 3'd6;

   typedef enum logic [2:0] {
      IDLE = ST_IDLE,
      LEN  = ST_LEN,
      LO   = ST_LO,
      HI   = ST_HI,
      SUM  = ST_SUM,
      RUN  = ST_RUN,
      ERR  = ST_ERR
   } state_t;

   // Instruction word layout: {arg, opcode}
   localparam int OPC_W   = 8;
   localparam int ARG_W   = 8;
   localparam int INSTR_W = OPC_W + ARG_W;

   localparam logic [INSTR_W-1:0] NOP_INSTR = 16'h0000;

   // Opcodes understood by the sequencer
   localparam logic [OPC_W-1:0] OP_NOP   = 8'h00;
   localparam logic [OPC_W-1:0] OP_FILL  = 8'h01;
   localparam logic [OPC_W-1:0] OP_HEAT  = 8'h02;
   localparam logic [OPC_W-1:0] OP_WASH  = 8'h03;
   localparam logic [OPC_W-1:0] OP_RINSE = 8'h04;
   localparam logic [OPC_W-1:0] OP_SPIN  = 8'h05;
   localparam logic [OPC_W-1:0] OP_DRAIN = 8'h06;
   localparam logic [OPC_W-1:0] OP_WAIT  = 8'h07;
   localparam logic [OPC_W-1:0] OP_HALT  = 8'hFF;

endpackage

// File: rtl/program_loader_prog_mem.sv
// Instruction store: DEPTH x 16 flop array, one write port, one read port.
// Write visible the cycle after we; read is combinational (zero latency).
// No backpressure; write accepted every cycle we is high.
module prog_mem
   import program_loader_pkg::*;
#(
   parameter int DEPTH = 256
) (
   input  logic               clk,
   input  logic               we,
   input  logic [7:0]         waddr,
   input  logic [INSTR_W-1:0] wdata,
   input  logic [7:0]         raddr,
   output logic [INSTR_W-1:0] rdata
);

   logic [INSTR_W-1:0] mem [DEPTH];

   // Synchronous write; contents deliberately not reset
   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   // Asynchronous read so fetch has no latency
   always_comb begin
      rdata = mem[raddr];
   end

endmodule

// File: rtl/program_loader.sv
// Byte-serial program loader with XOR checksum and instruction fetch port.
// One byte accepted per cycle; instr combinational from pc (zero latency).
// load_ready high only while a frame is being received; load_start aborts.
module program_loader
   import program_loader_pkg::*;
#(
   parameter int DEPTH = 256
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               load_start,
   input  logic               load_valid,
   input  logic [7:0]         load_data,
   output logic               load_ready,
   output logic               load_done,
   output logic               load_err,
   input  logic [7:0]         pc,
   output logic [INSTR_W-1:0] instr,
   output logic               ena
);

   state_t             state;
   logic [8:0]         wp;        // 9 bits so it can reach 256
   logic [8:0]         count;     // instruction count N, 1..256
   logic [OPC_W-1:0]   opcode;
   logic [7:0]         csum;
   logic               xfer;
   logic               mem_we;
   logic [8:0]         wp_next;
   logic [INSTR_W-1:0] mem_rdata;

   assign xfer    = load_valid & load_ready;
   assign wp_next = wp + 9'd1;
   // load_start drops any byte offered in the same cycle, including writes
   assign mem_we  = (state == HI) & xfer & ~load_start;

   // Ready while the frame is still being received
   always_comb begin
      load_ready = (state == LEN) | (state == LO) | (state == HI) | (state == SUM);
   end

   // Frame FSM, pointer, count and running checksum
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         wp        <= 9'd0;
         count     <= 9'd0;
         opcode    <= '0;
         csum      <= 8'h00;
         ena       <= 1'b0;
         load_err  <= 1'b0;
         load_done <= 1'b0;
      end else if (load_start) begin
         state     <= LEN;
         wp        <= 9'd0;
         csum      <= 8'h00;
         ena       <= 1'b0;
         load_err  <= 1'b0;
         load_done <= 1'b0;
      end else begin
         load_done <= 1'b0;
         case (state)
            LEN: if (xfer) begin
               count <= (load_data == 8'h00) ? 9'd256 : {1'b0, load_data};
               wp    <= 9'd0;
               csum  <= csum ^ load_data;
               state <= LO;
            end
            LO: if (xfer) begin
               opcode <= load_data;
               csum   <= csum ^ load_data;
               state  <= HI;
            end
            HI: if (xfer) begin
               wp    <= wp_next;
               csum  <= csum ^ load_data;
               state <= (wp_next == count) ? SUM : LO;
            end
            SUM: if (xfer) begin
               csum <= csum ^ load_data;
               if (load_data == csum) begin
                  state     <= RUN;
                  ena       <= 1'b1;
                  load_done <= 1'b1;
               end else begin
                  state    <= ERR;
                  load_err <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   prog_mem #(
      .DEPTH (DEPTH)
   ) u_prog_mem (
      .clk   (clk),
      .we    (mem_we),
      .waddr (wp[7:0]),
      .wdata ({load_data, opcode}),
      .raddr (pc),
      .rdata (mem_rdata)
   );

   // Fetch: only a verified program within its length is visible
   always_comb begin
      instr = NOP_INSTR;
      if (state == RUN && ({1'b0, pc} < count)) begin
         instr = mem_rdata;
      end
   end

endmodule

// File: tb/tb_program_loader.sv
// Randomized self-checking bench for program_loader against a frame-level model.
// Model decodes whole frames with plain arithmetic; DUT sampled away from edges.
// Exercises valid/ready gaps, abort, full length, bad checksum and reset.
module tb_program_loader;

   typedef logic [7:0] bq_t [$];

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        load_start = 1'b0;
   logic        load_valid = 1'b0;
   logic [7:0]  load_data = 8'h00;
   logic        load_ready;
   logic        load_done;
   logic        load_err;
   logic [7:0]  pc = 8'h00;
   logic [15:0] instr;
   logic        ena;

   int n_checks = 0;
   int n_errors = 0;
   int done_cnt = 0;

   // Reference model state
   logic [15:0] model_mem [256];
   int          exp_n    = 0;
   bit          exp_ena  = 0;
   bit          exp_err  = 0;
   int          exp_done = 0;

   program_loader #(.DEPTH(256)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .load_start (load_start),
      .load_valid (load_valid),
      .load_data  (load_data),
      .load_ready (load_ready),
      .load_done  (load_done),
      .load_err   (load_err),
      .pc         (pc),
      .instr      (instr),
      .ena        (ena)
   );

   always #5 clk = ~clk;

   // Count cycles with load_done high
   always @(negedge clk) if (load_done === 1'b1) done_cnt++;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   // Frame-level model: decode N, instructions and checksum from the byte list
   task automatic model_frame(input bq_t f);
      int n;
      logic [7:0] x;
      n = (f[0] == 8'h00) ? 256 : int'(f[0]);
      for (int i = 0; i < n; i++) model_mem[i] = {f[2 + 2*i], f[1 + 2*i]};
      x = 8'h00;
      for (int j = 0; j <= 2*n; j++) x = x ^ f[j];
      exp_n    = n;
      exp_ena  = (f[2*n + 1] == x);
      exp_err  = !exp_ena;
      exp_done = exp_ena ? 1 : 0;
   endtask

   task automatic build_frame(input int n, input bit corrupt, output bq_t f);
      logic [7:0] x;
      f = {};
      f.push_back(n == 256 ? 8'h00 : 8'(n));
      for (int i = 0; i < 2*n; i++) f.push_back(8'($urandom));
      x = 8'h00;
      foreach (f[j]) x = x ^ f[j];
      if (corrupt) x = x ^ 8'(1 << $urandom_range(0, 7));
      f.push_back(x);
   endtask

   task automatic pulse_start();
      @(posedge clk); #1;
      load_start = 1'b1;
      @(posedge clk); #1;
      load_start = 1'b0;
      done_cnt = 0;
      check("ready_after_start", load_ready, 1);
   endtask

   task automatic send_byte(input logic [7:0] b);
      bit acc;
      bit ok;
      load_valid = 1'b1;
      load_data  = b;
      ok = 0;
      for (int t = 0; t < 20; t++) begin
         acc = load_ready;
         @(posedge clk); #1;
         if (acc) begin
            ok = 1;
            break;
         end
      end
      load_valid = 1'b0;
      if (!ok) check("accept_timeout", 0, 1);
   endtask

   task automatic send_bytes(input bq_t f, input int maxgap);
      foreach (f[k]) begin
         int gap;
         gap = (maxgap > 0) ? $urandom_range(0, maxgap) : 0;
         repeat (gap) begin
            @(posedge clk); #1;
         end
         send_byte(f[k]);
      end
   endtask

   task automatic verify(input string tag);
      logic [15:0] e;
      @(negedge clk);
      check({tag, "_ena"}, ena, exp_ena);
      check({tag, "_err"}, load_err, exp_err);
      check({tag, "_ready"}, load_ready, 0);
      for (int i = 0; i < 256; i++) begin
         @(negedge clk);
         pc = 8'(i);
         #1;
         e = (exp_ena && i < exp_n) ? model_mem[i] : 16'h0000;
         check($sformatf("%s_pc%0d", tag, i), instr, e);
      end
      check({tag, "_done_cnt"}, done_cnt, exp_done);
   endtask

   initial begin
      bq_t f;
      bq_t good;
      good = '{8'h02, 8'h11, 8'h05, 8'h01, 8'h0A, 8'h1D};

      // Reset values
      repeat (3) @(posedge clk);
      #1;
      check("rst_ena", ena, 0);
      check("rst_ready", load_ready, 0);
      check("rst_done", load_done, 0);
      check("rst_err", load_err, 0);
      check("rst_instr", instr, 16'h0000);
      @(negedge clk);
      rst_n = 1'b1;

      // Valid program
      pulse_start();
      send_bytes(good, 0);
      model_frame(good);
      check("valid_model_ok", exp_ena, 1);
      verify("valid");
      @(negedge clk); pc = 8'd0; #1; check("valid_pc0", instr, 16'h0511);
      @(negedge clk); pc = 8'd1; #1; check("valid_pc1", instr, 16'h0A01);
      @(negedge clk); pc = 8'd2; #1; check("valid_pc2", instr, 16'h0000);

      // Bad checksum
      f = good;
      f[5] = 8'h1C;
      pulse_start();
      send_bytes(f, 0);
      model_frame(f);
      verify("badsum");

      // Gaps on load_valid
      pulse_start();
      send_bytes(good, 3);
      model_frame(good);
      verify("gaps");

      // Abort while running: start wins over the simultaneous byte 55
      @(posedge clk); #1;
      load_start = 1'b1;
      load_valid = 1'b1;
      load_data  = 8'h55;
      @(posedge clk); #1;
      load_start = 1'b0;
      load_valid = 1'b0;
      done_cnt   = 0;
      check("abort_ena", ena, 0);
      check("abort_ready", load_ready, 1);
      f = '{8'h01, 8'hAA, 8'hBB, 8'h10};
      f[3] = f[0] ^ f[1] ^ f[2];
      send_bytes(f, 0);
      model_frame(f);
      verify("abort");

      // Full length, mem[i] = {i, ~i}
      f = {};
      f.push_back(8'h00);
      for (int i = 0; i < 256; i++) begin
         logic [7:0] v;
         v = 8'(i);
         f.push_back(~v);
         f.push_back(v);
      end
      begin
         logic [7:0] x;
         x = 8'h00;
         foreach (f[j]) x = x ^ f[j];
         f.push_back(x);
      end
      pulse_start();
      send_bytes(f, 0);
      model_frame(f);
      verify("full");
      @(negedge clk); pc = 8'hFF; #1; check("full_pc255", instr, 16'hFF00);

      // Random frames, some with a corrupted checksum
      for (int it = 0; it < 12; it++) begin
         int n;
         bit bad;
         n   = ($urandom_range(0, 9) == 0) ? 256 : $urandom_range(1, 12);
         bad = ($urandom_range(0, 3) == 0);
         build_frame(n, bad, f);
         pulse_start();
         send_bytes(f, (n == 256) ? 0 : 2);
         model_frame(f);
         verify($sformatf("rnd%0d", it));
      end

      // Reset mid-frame after the third byte
      pulse_start();
      send_byte(good[0]);
      send_byte(good[1]);
      send_byte(good[2]);
      rst_n = 1'b0;
      #1;
      pc = 8'd0;
      #1;
      check("midrst_ena", ena, 0);
      check("midrst_ready", load_ready, 0);
      check("midrst_err", load_err, 0);
      check("midrst_done", load_done, 0);
      check("midrst_instr", instr, 16'h0000);
      @(negedge clk);
      rst_n = 1'b1;
      pulse_start();
      send_bytes(good, 0);
      model_frame(good);
      verify("after_rst");

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
